// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between requester 0 (control unit) and 1 (aux/IO); round-robin, or fixed priority with ALU_ARB_FIXED_PRIO_EN.
// Latency: gnt the cycle after req is sampled, done ALU_LATENCY+1 cycles after gnt; all outputs registered.
// Backpressure: requester holds req until gnt; requests are not sampled while an op is in flight.
module alu_arbiter #(
  parameter int reg_width   = 12,
  parameter int ALU_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [2:0]           op0,
  input  logic [2:0]           op1,
  input  logic [reg_width-1:0] a0,
  input  logic [reg_width-1:0] a1,
  input  logic [reg_width-1:0] b0,
  input  logic [reg_width-1:0] b1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 done0,
  output logic                 done1,
  output logic [reg_width-1:0] rdata,
  output logic                 rzflag,
  output logic                 busy,
  output logic [2:0]           alu_op,
  output logic [reg_width-1:0] alu_ac,
  output logic [reg_width-1:0] alu_bus,
  input  logic [reg_width-1:0] alu_result,
  input  logic                 alu_zflag
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP     = 3'b000;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;
  localparam logic [3:0] CNT_INIT   = 4'(ALU_LATENCY - 1);

  state_t               state_q, state_d;
  logic                 arb_take;
  logic                 arb_win;
  logic [2:0]           win_op;
  logic [reg_width-1:0] win_a;
  logic [reg_width-1:0] win_b;

  logic                 owner_q, owner_d;
  logic                 illegal_q, illegal_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 gnt0_q, gnt0_d;
  logic                 gnt1_q, gnt1_d;
  logic                 done0_q, done0_d;
  logic                 done1_q, done1_d;
  logic [reg_width-1:0] rdata_q, rdata_d;
  logic                 rzflag_q, rzflag_d;
  logic                 busy_q, busy_d;
  logic [2:0]           alu_op_q, alu_op_d;
  logic [reg_width-1:0] alu_ac_q, alu_ac_d;
  logic [reg_width-1:0] alu_bus_q, alu_bus_d;

  // New requests are only looked at when no op is in flight (IDLE) or one is just finishing (DONE).
  assign arb_take = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && (req0 || req1);

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    arb_win = ~req0;
  end
`else
  logic last_grant_q, last_grant_d;

  always_comb begin
    arb_win = req1;
    if (req0 && req1) begin
      arb_win = ~last_grant_q;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (arb_take) begin
      last_grant_d = arb_win;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign win_op = arb_win ? op1 : op0;
  assign win_a  = arb_win ? a1  : a0;
  assign win_b  = arb_win ? b1  : b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE,
      ST_DONE:  state_d = arb_take ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (cnt_q == 4'd0) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    owner_d   = owner_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    rdata_d   = rdata_q;
    rzflag_d  = rzflag_q;
    alu_op_d  = OP_NOP;
    alu_ac_d  = alu_ac_q;
    alu_bus_d = alu_bus_q;
    busy_d    = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE,
      ST_DONE: begin
        if (arb_take) begin
          owner_d   = arb_win;
          illegal_d = (win_op == OP_ILLEGAL);
          gnt0_d    = ~arb_win;
          gnt1_d    = arb_win;
          // An illegal op still runs the handshake but never reaches the ALU.
          alu_op_d  = (win_op == OP_ILLEGAL) ? OP_NOP : win_op;
          alu_ac_d  = win_a;
          alu_bus_d = win_b;
        end
      end
      ST_ISSUE: begin
        cnt_d = CNT_INIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (!illegal_q) begin
            rdata_d  = alu_result;
            rzflag_d = alu_zflag;
          end
          done0_d = ~owner_q;
          done1_d = owner_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q   <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= 4'd0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      rdata_q   <= '0;
      rzflag_q  <= 1'b0;
      busy_q    <= 1'b0;
      alu_op_q  <= OP_NOP;
      alu_ac_q  <= '0;
      alu_bus_q <= '0;
    end else begin
      owner_q   <= owner_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      rdata_q   <= rdata_d;
      rzflag_q  <= rzflag_d;
      busy_q    <= busy_d;
      alu_op_q  <= alu_op_d;
      alu_ac_q  <= alu_ac_d;
      alu_bus_q <= alu_bus_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign rdata   = rdata_q;
  assign rzflag  = rzflag_q;
  assign busy    = busy_q;
  assign alu_op  = alu_op_q;
  assign alu_ac  = alu_ac_q;
  assign alu_bus = alu_bus_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: instance A (ALU_LATENCY=1) and instance B (ALU_LATENCY=3), each with a small ALU model.
// Expected completions are queued when ops are driven and compared when done pulses.
module tb_alu_arbiter;
  localparam int W = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         req0, req1;
  logic [2:0]   op0, op1;
  logic [W-1:0] a0, a1, b0, b1;
  logic         gnt0, gnt1, done0, done1, rzflag, busy;
  logic [W-1:0] rdata, alu_ac, alu_bus;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_result = '0;
  logic         alu_zflag;

  logic         r3_req0;
  logic [2:0]   r3_op0;
  logic [W-1:0] r3_a0, r3_b0;
  logic         r3_gnt0, r3_gnt1, r3_done0, r3_done1, r3_rzflag, r3_busy;
  logic [W-1:0] r3_rdata, r3_ac, r3_bus;
  logic [2:0]   r3_alu_op;
  logic [W-1:0] r3_s0 = '0, r3_s1 = '0, r3_s2 = '0;
  logic [W-1:0] r3_result;
  logic         r3_zflag;

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
    logic         z;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb3_q[$];
  int n_chk = 0;
  int n_pass = 0;
  logic [W-1:0] mdl_data = '0;
  logic         mdl_z = 1'b0;
  logic         tb_last = 1'b1;

  alu_arbiter #(.reg_width(W), .ALU_LATENCY(1)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .rzflag(rzflag), .busy(busy),
    .alu_op(alu_op), .alu_ac(alu_ac), .alu_bus(alu_bus),
    .alu_result(alu_result), .alu_zflag(alu_zflag)
  );

  alu_arbiter #(.reg_width(W), .ALU_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .req0(r3_req0), .req1(1'b0), .op0(r3_op0), .op1(3'b000),
    .a0(r3_a0), .a1('0), .b0(r3_b0), .b1('0),
    .gnt0(r3_gnt0), .gnt1(r3_gnt1), .done0(r3_done0), .done1(r3_done1),
    .rdata(r3_rdata), .rzflag(r3_rzflag), .busy(r3_busy),
    .alu_op(r3_alu_op), .alu_ac(r3_ac), .alu_bus(r3_bus),
    .alu_result(r3_result), .alu_zflag(r3_zflag)
  );

  function automatic logic [W-1:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'b001:  alu_f = b;
      3'b010:  alu_f = a + b;
      3'b011:  alu_f = a - b;
      3'b100:  alu_f = a * b;
      3'b101:  alu_f = a + 1'b1;
      default: alu_f = '0;
    endcase
  endfunction

  // ALU models: registered result that holds while alu_op is idle.
  always @(posedge clk) begin
    if (alu_op != 3'b000) alu_result <= alu_f(alu_op, alu_ac, alu_bus);
  end
  assign alu_zflag = (alu_result == '0);

  always @(posedge clk) begin
    if (r3_alu_op != 3'b000) r3_s0 <= alu_f(r3_alu_op, r3_ac, r3_bus);
    r3_s1 <= r3_s0;
    r3_s2 <= r3_s1;
  end
  assign r3_result = r3_s2;
  assign r3_zflag  = (r3_s2 == '0);

  always @(negedge clk) begin
    exp_t e;
    if (done0 || done1) begin
      n_chk++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_a_unexpected: done0=%b done1=%b, required no completion", done0, done1);
      end else begin
        e = sb_q.pop_front();
        if ({done0, done1, rdata, rzflag} !== {~e.id, e.id, e.data, e.z})
          $display("FAIL sb_a_result: got done0=%b done1=%b rdata=%h z=%b, required done0=%b done1=%b rdata=%h z=%b",
                   done0, done1, rdata, rzflag, ~e.id, e.id, e.data, e.z);
        else n_pass++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (r3_done0 || r3_done1) begin
      n_chk++;
      if (sb3_q.size() == 0) begin
        $display("FAIL sb_b_unexpected: done0=%b done1=%b, required no completion", r3_done0, r3_done1);
      end else begin
        e = sb3_q.pop_front();
        if ({r3_done0, r3_done1, r3_rdata, r3_rzflag} !== {~e.id, e.id, e.data, e.z})
          $display("FAIL sb_b_result: got done0=%b done1=%b rdata=%h z=%b, required done0=%b done1=%b rdata=%h z=%b",
                   r3_done0, r3_done1, r3_rdata, r3_rzflag, ~e.id, e.id, e.data, e.z);
        else n_pass++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic id, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (op != 3'b111) begin
      mdl_data = alu_f(op, a, b);
      mdl_z    = (mdl_data == '0);
    end
    e.id = id; e.data = mdl_data; e.z = mdl_z;
    sb_q.push_back(e);
  endtask

  task automatic model_reset();
    sb_q.delete();
    sb3_q.delete();
    mdl_data = '0;
    mdl_z    = 1'b0;
    tb_last  = 1'b1;
  endtask

  task automatic test_reset();
    req0 = 0; req1 = 0; op0 = '0; op1 = '0; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    r3_req0 = 0; r3_op0 = '0; r3_a0 = '0; r3_b0 = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    n_chk++;
    if ({gnt0, gnt1, done0, done1, rdata, rzflag, busy, alu_op, alu_ac, alu_bus} !== '0)
      $display("FAIL reset_a: got gnt=%b%b done=%b%b rdata=%h z=%b busy=%b op=%b ac=%h bus=%h, required all 0",
               gnt0, gnt1, done0, done1, rdata, rzflag, busy, alu_op, alu_ac, alu_bus);
    else n_pass++;
    n_chk++;
    if ({r3_gnt0, r3_gnt1, r3_done0, r3_done1, r3_rdata, r3_rzflag, r3_busy, r3_alu_op, r3_ac, r3_bus} !== '0)
      $display("FAIL reset_b: got busy=%b op=%b rdata=%h, required all 0", r3_busy, r3_alu_op, r3_rdata);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mid_reset();
    req0 = 1'b1; op0 = 3'($urandom_range(1, 6)); a0 = W'($urandom); b0 = W'($urandom);
    req1 = 1'($urandom_range(0, 1)); op1 = 3'($urandom_range(1, 6)); a1 = W'($urandom); b1 = W'($urandom);
    tick();
    n_chk++;
    if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b, required 1", busy);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({gnt0, gnt1, done0, done1, rdata, rzflag, busy, alu_op, alu_ac, alu_bus} !== '0)
      $display("FAIL midrst_outputs: got gnt=%b%b done=%b%b rdata=%h busy=%b op=%b ac=%h bus=%h, required all 0",
               gnt0, gnt1, done0, done1, rdata, busy, alu_op, alu_ac, alu_bus);
    else n_pass++;
    req0 = 0; req1 = 0;
    model_reset();
    reset = 1'b1;
    repeat (4) tick();
    n_chk++;
    if (busy !== 1'b0) $display("FAIL midrst_busy_after: got %b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_single0();
    req0 = 1; op0 = 3'b010; a0 = 12'h402; b0 = 12'h0C8;
    push_exp(1'b0, op0, a0, b0);
    tb_last = 1'b0;
    tick();
    n_chk++;
    if ({gnt0, gnt1, alu_op, alu_ac, alu_bus, busy} !== {1'b1, 1'b0, 3'b010, 12'h402, 12'h0C8, 1'b1})
      $display("FAIL add_issue: got gnt=%b%b op=%b ac=%h bus=%h busy=%b, required gnt=10 op=010 ac=402 bus=0c8 busy=1",
               gnt0, gnt1, alu_op, alu_ac, alu_bus, busy);
    else n_pass++;
    req0 = 0;
    tick();
    n_chk++;
    if ({gnt0, alu_op, done0, done1} !== {1'b0, 3'b000, 1'b0, 1'b0})
      $display("FAIL add_wait: got gnt0=%b op=%b done=%b%b, required gnt0=0 op=000 done=00", gnt0, alu_op, done0, done1);
    else n_pass++;
    tick();
    n_chk++;
    if ({done0, done1, rdata, rzflag} !== {1'b1, 1'b0, 12'h4CA, 1'b0})
      $display("FAIL add_done: got done=%b%b rdata=%h z=%b, required done=10 rdata=4ca z=0", done0, done1, rdata, rzflag);
    else n_pass++;
    tick();
    n_chk++;
    if ({done0, busy} !== 2'b00) $display("FAIL add_idle: got done0=%b busy=%b, required 0 0", done0, busy);
    else n_pass++;
  endtask

  task automatic test_illegal();
    req0 = 1; op0 = 3'b111; a0 = 12'h005; b0 = 12'h007;
    push_exp(1'b0, op0, a0, b0);
    tb_last = 1'b0;
    tick();
    n_chk++;
    if ({gnt0, alu_op, busy} !== {1'b1, 3'b000, 1'b1})
      $display("FAIL illegal_issue: got gnt0=%b op=%b busy=%b, required 1 000 1", gnt0, alu_op, busy);
    else n_pass++;
    req0 = 0;
    tick();
    tick();
    n_chk++;
    if ({done0, rdata, rzflag} !== {1'b1, 12'h4CA, 1'b0})
      $display("FAIL illegal_done: got done0=%b rdata=%h z=%b, required 1 4ca 0", done0, rdata, rzflag);
    else n_pass++;
    tick();
  endtask

  task automatic test_single1();
    req1 = 1; op1 = 3'b011; a1 = 12'h008; b1 = 12'h008;
    push_exp(1'b1, op1, a1, b1);
    tb_last = 1'b1;
    tick();
    n_chk++;
    if ({gnt0, gnt1, alu_op} !== {1'b0, 1'b1, 3'b011})
      $display("FAIL sub_issue: got gnt=%b%b op=%b, required gnt=01 op=011", gnt0, gnt1, alu_op);
    else n_pass++;
    req1 = 0;
    tick();
    tick();
    n_chk++;
    if ({done0, done1, rdata, rzflag} !== {1'b0, 1'b1, 12'h000, 1'b1})
      $display("FAIL sub_done: got done=%b%b rdata=%h z=%b, required done=01 rdata=000 z=1", done0, done1, rdata, rzflag);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_id;
    int k;
    req0 = 1; op0 = 3'b010; a0 = 12'h011; b0 = 12'h022;
    req1 = 1; op1 = 3'b011; a1 = 12'h00F; b1 = 12'h00F;
    for (int g = 0; g < 3; g++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_id = 1'b0;
`else
      exp_id = ~tb_last;
`endif
      tb_last = exp_id;
      if (exp_id) push_exp(1'b1, op1, a1, b1);
      else        push_exp(1'b0, op0, a0, b0);
      k = 0;
      do begin
        tick();
        k++;
      end while (!(gnt0 || gnt1) && k < 8);
      n_chk++;
      if ({gnt0, gnt1} !== {~exp_id, exp_id})
        $display("FAIL rr_grant%0d: got gnt=%b%b, required gnt=%b%b", g, gnt0, gnt1, ~exp_id, exp_id);
      else n_pass++;
      n_chk++;
      if (k !== ((g == 0) ? 1 : 3))
        $display("FAIL rr_spacing%0d: got %0d cycles, required %0d", g, k, (g == 0) ? 1 : 3);
      else n_pass++;
      if (g == 2) begin
        req0 = 0;
        req1 = 0;
      end
    end
    repeat (3) tick();
    n_chk++;
    if (busy !== 1'b0) $display("FAIL rr_drain: got busy=%b, required 0", busy);
    else n_pass++;
  endtask

  task automatic test_latency3();
    exp_t e;
    logic seen;
    r3_req0 = 1; r3_op0 = 3'b100; r3_a0 = 12'h008; r3_b0 = 12'h009;
    e.id = 1'b0; e.data = alu_f(r3_op0, r3_a0, r3_b0); e.z = (e.data == '0);
    sb3_q.push_back(e);
    tick();
    n_chk++;
    if ({r3_gnt0, r3_alu_op, r3_ac, r3_bus} !== {1'b1, 3'b100, 12'h008, 12'h009})
      $display("FAIL lat3_issue: got gnt0=%b op=%b ac=%h bus=%h, required 1 100 008 009", r3_gnt0, r3_alu_op, r3_ac, r3_bus);
    else n_pass++;
    r3_req0 = 0;
    seen = 1'b0;
    repeat (3) begin
      tick();
      seen |= r3_done0;
    end
    n_chk++;
    if (seen !== 1'b0) $display("FAIL lat3_early_done: got done0 before cycle 5, required none");
    else n_pass++;
    tick();
    n_chk++;
    if ({r3_done0, r3_rdata, r3_rzflag} !== {1'b1, 12'h048, 1'b0})
      $display("FAIL lat3_done: got done0=%b rdata=%h z=%b, required 1 048 0", r3_done0, r3_rdata, r3_rzflag);
    else n_pass++;
    tick();
    r3_req0 = 1;
    tick();
    r3_req0 = 0;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({r3_busy, r3_done0, r3_gnt0, r3_alu_op, r3_rdata, r3_rzflag} !== '0)
      $display("FAIL lat3_reset: got busy=%b done0=%b gnt0=%b op=%b rdata=%h, required all 0",
               r3_busy, r3_done0, r3_gnt0, r3_alu_op, r3_rdata);
    else n_pass++;
    model_reset();
    reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= r3_done0 | r3_done1;
    end
    n_chk++;
    if ({seen, r3_busy} !== 2'b00) $display("FAIL lat3_dropped: got done_seen=%b busy=%b, required 0 0", seen, r3_busy);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mid_reset();
    test_single0();
    test_illegal();
    test_single1();
    test_back_to_back();
    test_latency3();
    repeat (2) tick();
    n_chk++;
    if ((sb_q.size() + sb3_q.size()) !== 0)
      $display("FAIL sb_drain: got %0d pending completions, required 0", sb_q.size() + sb3_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
